// File: rtl/ip_counter_cfg_pkg.sv
// Shared types and constants for the ip_counter configuration sequencer.
package ip_counter_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RESP     = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         REG_STRIDE    = 4;

  // Byte offset of register idx from the bank base.
  function automatic logic [31:0] reg_offset(input logic [3:0] idx);
    return 32'(idx) * 32'(REG_STRIDE);
  endfunction

endpackage

// File: rtl/ip_counter_cfg_seq.sv
// AXI4-Lite master that writes a block of configuration words into the
// ip_counter register bank, optionally reads them back for comparison, and
// reports done/error with the index of the first failing register.
module ip_counter_cfg_seq
  import ip_counter_cfg_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            VERIFY             = 1,
  parameter int                            TIMEOUT_CYCLES     = 256
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   start,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [1:0]                             err_code,
  output logic [3:0]                             err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                             M_AXI_AWPROT,
  output logic                                   M_AXI_AWVALID,
  input  logic                                   M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                                   M_AXI_WVALID,
  input  logic                                   M_AXI_WREADY,
  input  logic [1:0]                             M_AXI_BRESP,
  input  logic                                   M_AXI_BVALID,
  output logic                                   M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                             M_AXI_ARPROT,
  output logic                                   M_AXI_ARVALID,
  input  logic                                   M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                             M_AXI_RRESP,
  input  logic                                   M_AXI_RVALID,
  output logic                                   M_AXI_RREADY
);

  localparam int              DW       = C_M_AXI_DATA_WIDTH;
  localparam int              IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      LAST     = 4'(NUM_REGS - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic [NUM_REGS-1:0][DW-1:0]  shadow_q, shadow_d;
  logic                         aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
  logic                         error_q, error_d;
  err_code_e                    code_q, code_d;
  logic [3:0]                   eidx_q, eidx_d;
  logic [TW-1:0]                tmo_q;
  logic                         tmo_hit;
  logic [IW-1:0]                sel;

  assign sel     = idx_q[IW-1:0];
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next state, register index and result flags; first failure moves to DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    aw_ok_d  = aw_ok_q;
    w_ok_d   = w_ok_q;
    error_d  = error_q;
    code_d   = code_q;
    eidx_d   = eidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = cfg_data;
          idx_d    = '0;
          error_d  = 1'b0;
          code_d   = ERR_NONE;
          eidx_d   = '0;
          state_d  = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        aw_ok_d = aw_ok_q | M_AXI_AWREADY;
        w_ok_d  = w_ok_q | M_AXI_WREADY;
        if (aw_ok_d && w_ok_d) begin
          state_d = S_WR_RESP;
        end else if (tmo_hit) begin
          state_d = S_DONE; error_d = 1'b1; code_d = ERR_TIMEOUT; eidx_d = idx_q;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            state_d = S_DONE; error_d = 1'b1; code_d = ERR_RESP; eidx_d = idx_q;
          end else if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = (VERIFY != 0) ? S_RD_REQ : S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_WR_REQ;
          end
        end else if (tmo_hit) begin
          state_d = S_DONE; error_d = 1'b1; code_d = ERR_TIMEOUT; eidx_d = idx_q;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          state_d = S_RD_RESP;
        end else if (tmo_hit) begin
          state_d = S_DONE; error_d = 1'b1; code_d = ERR_TIMEOUT; eidx_d = idx_q;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != AXI_RESP_OKAY) begin
            state_d = S_DONE; error_d = 1'b1; code_d = ERR_RESP; eidx_d = idx_q;
          end else if (M_AXI_RDATA != shadow_q[sel]) begin
            state_d = S_DONE; error_d = 1'b1; code_d = ERR_MISMATCH; eidx_d = idx_q;
          end else if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_RD_REQ;
          end
        end else if (tmo_hit) begin
          state_d = S_DONE; error_d = 1'b1; code_d = ERR_TIMEOUT; eidx_d = idx_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Handshake tracking only lives for one write request.
    if (state_d != S_WR_REQ) begin
      aw_ok_d = 1'b0;
      w_ok_d  = 1'b0;
    end
  end

  // Sequencer state, shadow copy of the configuration and sticky result.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= ERR_NONE;
      eidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      aw_ok_q  <= aw_ok_d;
      w_ok_q   <= w_ok_d;
      error_q  <= error_d;
      code_q   <= code_d;
      eidx_q   <= eidx_d;
    end
  end

  // Per-state wait counter, restarted whenever the state changes.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || (state_d != state_q)) begin
      tmo_q <= '0;
    end else if (state_q != S_IDLE && state_q != S_DONE) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign error    = error_q;
  assign err_code = code_q;
  assign err_idx  = eidx_q;

  assign M_AXI_AWADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(reg_offset(idx_q));
  assign M_AXI_ARADDR  = M_AXI_AWADDR;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_ok_q;
  assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_ok_q;
  assign M_AXI_WDATA   = shadow_q[sel];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARVALID = (state_q == S_RD_REQ);
  assign M_AXI_RREADY  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_ip_counter_cfg_seq.sv
// Bench for ip_counter_cfg_seq: behavioural AXI4-Lite slave with delay and
// fault knobs, transaction logs, and a per-scenario outcome model.
module tb_ip_counter_cfg_seq;
  localparam int NR  = 4;
  localparam int TMO = 256;

  logic ACLK = 1'b0, ARESETN = 1'b0, start = 1'b0;
  logic [NR*32-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [3:0] err_idx;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  always #5 ACLK = ~ACLK;

  ip_counter_cfg_seq #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NR),
                       .BASE_ADDR(32'h0), .VERIFY(1), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_idx(err_idx),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int errors = 0, checks = 0;

  // slave knobs (-1 = no fault)
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  int bad_b = -1, bad_r = -1, corr_idx = -1;
  logic [31:0] corr_mask = 32'h0;
  bit no_b = 1'b0;

  // slave state and logs
  int aw_wait, w_wait, ar_wait, r_wait, wr_n, rd_n, viol, bready_cyc;
  logic aw_got, w_got, rpend, awp_q, wp_q, arp_q;
  logic [31:0] aw_a, w_d, ar_a, awa_q, wd_q, ara_q;
  logic [31:0] mem [16];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int aw_hi[$], w_hi[$];
  logic aw_have, w_have;
  logic [31:0] a_now, d_now;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && (w_wait >= w_delay);
  assign arready = arvalid && (ar_wait >= ar_delay);
  assign aw_have = aw_got || (awvalid && awready);
  assign w_have  = w_got || (wvalid && wready);
  assign a_now   = (awvalid && awready) ? awaddr : aw_a;
  assign d_now   = (wvalid && wready) ? wdata : w_d;

  // Behavioural AXI4-Lite slave plus protocol monitor.
  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0; wr_n <= 0; rd_n <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; rpend <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0; awp_q <= 1'b0; wp_q <= 1'b0; arp_q <= 1'b0;
    end else begin
      if (start && !busy) begin
        aw_log.delete(); w_log.delete(); ar_log.delete(); aw_hi.delete(); w_hi.delete();
        bready_cyc <= 0; viol <= 0; wr_n <= 0; rd_n <= 0;
      end
      if (awvalid && awready) begin
        aw_log.push_back(awaddr); aw_hi.push_back(aw_wait + 1); aw_wait <= 0; aw_got <= 1'b1; aw_a <= awaddr;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin
        w_log.push_back(wdata); w_hi.push_back(w_wait + 1); w_wait <= 0; w_got <= 1'b1; w_d <= wdata;
      end else if (wvalid) w_wait <= w_wait + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_have && w_have && !bvalid) begin
        mem[a_now[5:2]] <= d_now; aw_got <= 1'b0; w_got <= 1'b0; wr_n <= wr_n + 1;
        if (!no_b) begin bvalid <= 1'b1; bresp <= (wr_n == bad_b) ? 2'b10 : 2'b00; end
      end
      if (bready) bready_cyc <= bready_cyc + 1;
      if (arvalid && arready) begin
        ar_log.push_back(araddr); ar_a <= araddr; rpend <= 1'b1; ar_wait <= 0; r_wait <= 0;
      end else if (arvalid) ar_wait <= ar_wait + 1;
      if (rpend && !rvalid) begin
        if (r_wait >= r_delay) begin
          rvalid <= 1'b1;
          rdata  <= mem[ar_a[5:2]] ^ ((rd_n == corr_idx) ? corr_mask : 32'h0);
          rresp  <= (rd_n == bad_r) ? 2'b10 : 2'b00;
        end else r_wait <= r_wait + 1;
      end
      if (rvalid && rready) begin rvalid <= 1'b0; rpend <= 1'b0; rd_n <= rd_n + 1; end
      // one outstanding transaction; VALID/payload held until handshake
      if ((awvalid || wvalid || arvalid) && (bvalid || rpend)) viol <= viol + 1;
      if (awp_q && (!awvalid || awaddr != awa_q)) viol <= viol + 1;
      if (wp_q && (!wvalid || wdata != wd_q)) viol <= viol + 1;
      if (arp_q && (!arvalid || araddr != ara_q)) viol <= viol + 1;
      awp_q <= awvalid && !awready; awa_q <= awaddr;
      wp_q  <= wvalid && !wready;   wd_q  <= wdata;
      arp_q <= arvalid && !arready; ara_q <= araddr;
    end
  end

  // Expected outcome of one sequence from the injected fault.
  // fault: 0 none, 1 BRESP error, 2 RRESP error, 3 RDATA corrupt, 4 no BVALID
  function automatic void model(input int fault, input int fidx,
                                output int ew, output int er, output int ecode, output int eidx);
    ew = NR; er = NR; ecode = 0; eidx = 0;
    case (fault)
      1: begin ew = fidx + 1; er = 0; ecode = 1; eidx = fidx; end
      2: begin er = fidx + 1; ecode = 1; eidx = fidx; end
      3: begin er = fidx + 1; ecode = 2; eidx = fidx; end
      4: begin ew = 1; er = 0; ecode = 3; eidx = 0; end
      default: ;
    endcase
  endfunction

  task automatic clear_knobs();
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;
    bad_b = -1; bad_r = -1; corr_idx = -1; corr_mask = 32'h0; no_b = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; start = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  function automatic logic [NR*32-1:0] rand_cfg();
    logic [NR*32-1:0] c;
    for (int i = 0; i < NR; i++) c[32*i +: 32] = $urandom;
    return c;
  endfunction

  // Pulse start, then wait (bounded) for done; optionally pulse start again mid-sequence.
  task automatic run_seq(input logic [NR*32-1:0] cfg, input int extra_at,
                         output bit tmo, output logic e, output logic [1:0] c, output logic [3:0] x);
    @(negedge ACLK); cfg_data = cfg; start = 1'b1;
    @(negedge ACLK); start = 1'b0; cfg_data = ~cfg;
    tmo = 1'b1; e = 1'bx; c = 2'bxx; x = 4'bxxxx;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin tmo = 1'b0; e = error; c = err_code; x = err_idx; break; end
      start = (k == extra_at);
      @(negedge ACLK);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, error, err_code, err_idx} !== 9'h0) begin
      errors++; $display("FAIL reset.status got=%b exp=0", {busy, done, error, err_code, err_idx});
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'h0) begin
      errors++; $display("FAIL reset.axi got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({wstrb, awprot, arprot} !== {4'hF, 6'h0}) begin
      errors++; $display("FAIL reset.strb_prot got=%h exp=%h", {wstrb, awprot, arprot}, {4'hF, 6'h0});
    end
  endtask

  task automatic test_basic();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg = {32'd4, 32'd3, 32'd2, 32'd1};
    clear_knobs();
    run_seq(cfg, -1, tmo, e, c, x);
    checks++; if (tmo) begin errors++; $display("FAIL basic.done_timeout got=none exp=done"); end
    checks++; if ({e, c} !== 3'b0) begin errors++; $display("FAIL basic.err got=%b exp=000", {e, c}); end
    checks++; if (aw_log.size() != NR || ar_log.size() != NR) begin
      errors++; $display("FAIL basic.counts got=%0d/%0d exp=%0d", aw_log.size(), ar_log.size(), NR); end
    for (int i = 0; i < NR && i < aw_log.size() && i < ar_log.size() && i < w_log.size(); i++) begin
      checks++;
      if (aw_log[i] !== 32'(4*i) || ar_log[i] !== 32'(4*i) || w_log[i] !== 32'(i + 1)) begin
        errors++; $display("FAIL basic.txn%0d got=%h/%h/%h exp=%h/%h/%h", i, aw_log[i], ar_log[i], w_log[i], 4*i, 4*i, i + 1);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL basic.protocol got=%0d exp=0", viol); end
    @(negedge ACLK);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic.after_done got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_aw_delay();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg = rand_cfg();
    clear_knobs(); aw_delay = 3;
    run_seq(cfg, -1, tmo, e, c, x);
    checks++; if (tmo || e !== 1'b0) begin errors++; $display("FAIL awdly.err got=%b%b exp=00", tmo, e); end
    checks++; if (aw_hi.size() != NR || w_log.size() != NR) begin
      errors++; $display("FAIL awdly.count got=%0d exp=%0d", aw_hi.size(), NR); end
    for (int i = 0; i < NR && i < aw_hi.size() && i < w_hi.size() && i < w_log.size(); i++) begin
      checks++;
      if (aw_hi[i] != 4 || w_hi[i] != 1 || w_log[i] !== cfg[32*i +: 32]) begin
        errors++; $display("FAIL awdly.reg%0d got=aw%0d w%0d d=%h exp=aw4 w1 d=%h", i, aw_hi[i], w_hi[i], w_log[i], cfg[32*i +: 32]);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL awdly.protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_bresp_err();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    clear_knobs(); bad_b = 2;
    run_seq(rand_cfg(), -1, tmo, e, c, x);
    checks++; if (tmo || {e, c, x} !== {1'b1, 2'd1, 4'd2}) begin
      errors++; $display("FAIL bresp.result got=%b/%0d/%0d exp=1/1/2", e, c, x); end
    checks++; if (aw_log.size() != 3 || ar_log.size() != 0) begin
      errors++; $display("FAIL bresp.txns got=%0d/%0d exp=3/0", aw_log.size(), ar_log.size()); end
  endtask

  task automatic test_rdata_corrupt();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    clear_knobs(); corr_idx = 1; corr_mask = 32'h2;
    run_seq({32'd4, 32'd3, 32'd2, 32'd1}, -1, tmo, e, c, x);
    checks++; if (tmo || {e, c, x} !== {1'b1, 2'd2, 4'd1}) begin
      errors++; $display("FAIL corrupt.result got=%b/%0d/%0d exp=1/2/1", e, c, x); end
    checks++; if (aw_log.size() != NR || ar_log.size() != 2) begin
      errors++; $display("FAIL corrupt.txns got=%0d/%0d exp=4/2", aw_log.size(), ar_log.size()); end
  endtask

  task automatic test_timeout();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg = rand_cfg();
    clear_knobs(); no_b = 1'b1;
    run_seq(cfg, 20, tmo, e, c, x);
    checks++; if (tmo || {e, c, x} !== {1'b1, 2'd3, 4'd0}) begin
      errors++; $display("FAIL timeout.result got=%b/%0d/%0d exp=1/3/0", e, c, x); end
    checks++; if (bready_cyc != TMO) begin errors++; $display("FAIL timeout.wait got=%0d exp=%0d", bready_cyc, TMO); end
    checks++; if (w_log.size() != 1 || w_log[0] !== cfg[31:0]) begin
      errors++; $display("FAIL timeout.writes got=%0d exp=1", w_log.size()); end
    repeat (2) @(negedge ACLK);
    checks++; if ({busy, bready, awvalid} !== 3'b000) begin
      errors++; $display("FAIL timeout.idle got=%b exp=000", {busy, bready, awvalid}); end
    clear_knobs(); do_reset();
  endtask

  task automatic test_reset_mid();
    bit tmo, seen; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg = rand_cfg();
    clear_knobs(); r_delay = 100;
    @(negedge ACLK); cfg_data = rand_cfg(); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rready) begin seen = 1'b1; break; end
      @(negedge ACLK);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid.reach_rd_resp got=0 exp=1"); end
    ARESETN = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, error} !== 8'h0) begin
      errors++; $display("FAIL rstmid.cleared got=%b exp=0", {awvalid, wvalid, bready, arvalid, rready, busy, done, error});
    end
    ARESETN = 1'b1; r_delay = 0;
    run_seq(cfg, -1, tmo, e, c, x);
    checks++; if (tmo || {e, c} !== 3'b0 || ar_log.size() != NR) begin
      errors++; $display("FAIL rstmid.rerun got=%b/%0d reads=%0d exp=0/0 reads=%0d", e, c, ar_log.size(), NR); end
  endtask

  task automatic test_back_to_back();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg2 = rand_cfg();
    clear_knobs();
    run_seq(rand_cfg(), -1, tmo, e, c, x);
    start = 1'b1; cfg_data = rand_cfg();
    @(negedge ACLK); start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b.start_on_done got=%b exp=0", busy); end
    run_seq(cfg2, -1, tmo, e, c, x);
    checks++; if (tmo || {e, c} !== 3'b0 || w_log.size() != NR || w_log[NR-1] !== cfg2[32*NR-1 -: 32]) begin
      errors++; $display("FAIL b2b.second got=%b/%0d writes=%0d exp=0/0 writes=%0d", e, c, w_log.size(), NR); end
  endtask

  task automatic test_random();
    bit tmo; logic e; logic [1:0] c; logic [3:0] x;
    logic [NR*32-1:0] cfg;
    int fault, fidx, ew, er, ecode, eidx;
    for (int it = 0; it < 24; it++) begin
      clear_knobs();
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      fault = $urandom_range(0, 3); fidx = $urandom_range(0, NR - 1);
      case (fault)
        1: bad_b = fidx;
        2: bad_r = fidx;
        3: begin corr_idx = fidx; corr_mask = $urandom | 32'h1; end
        default: ;
      endcase
      cfg = rand_cfg();
      model(fault, fidx, ew, er, ecode, eidx);
      run_seq(cfg, -1, tmo, e, c, x);
      checks++;
      if (tmo || e !== (ecode != 0) || c !== 2'(ecode) || x !== 4'(eidx)) begin
        errors++; $display("FAIL rand%0d.result got=%b/%0d/%0d exp=%0d/%0d/%0d", it, e, c, x, ecode != 0, ecode, eidx);
      end
      checks++;
      if (aw_log.size() != ew || w_log.size() != ew || ar_log.size() != er) begin
        errors++; $display("FAIL rand%0d.counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, aw_log.size(), w_log.size(), ar_log.size(), ew, ew, er);
      end
      for (int i = 0; i < w_log.size() && i < aw_log.size(); i++) begin
        checks++;
        if (aw_log[i] !== 32'(4*i) || w_log[i] !== cfg[32*i +: 32]) begin
          errors++; $display("FAIL rand%0d.wr%0d got=%h:%h exp=%h:%h", it, i, aw_log[i], w_log[i], 4*i, cfg[32*i +: 32]);
        end
      end
      for (int i = 0; i < ar_log.size(); i++) begin
        checks++;
        if (ar_log[i] !== 32'(4*i)) begin errors++; $display("FAIL rand%0d.rd%0d got=%h exp=%h", it, i, ar_log[i], 4*i); end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL rand%0d.protocol got=%0d exp=0", it, viol); end
    end
  endtask

  initial begin
    clear_knobs();
    do_reset();
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_rdata_corrupt();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
